// File: rtl/traffic_light_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// traffic_light_ctrl_pkg
// Shared definitions for the intersection controller: the state encoding and
// the lamp patterns. The state codes are also the values seen on state_o, so
// the display side can use the same numbering.
// -----------------------------------------------------------------------------
package traffic_light_ctrl_pkg;

    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_MAIN_G = 3'd1,
        S_MAIN_Y = 3'd2,
        S_AR1    = 3'd3,
        S_SIDE_G = 3'd4,
        S_SIDE_Y = 3'd5,
        S_AR2    = 3'd6,
        S_WALK   = 3'd7
    } state_t;

    // Lamp encoding is {R,Y,G}, one-hot.
    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    function automatic logic [2:0] main_lamp(input state_t s);
        logic [2:0] lamp;
        lamp = RED;
        case (s)
            S_MAIN_G: lamp = GRN;
            S_MAIN_Y: lamp = YEL;
            default:  lamp = RED;
        endcase
        return lamp;
    endfunction

    function automatic logic [2:0] side_lamp(input state_t s);
        logic [2:0] lamp;
        lamp = RED;
        case (s)
            S_SIDE_G: lamp = GRN;
            S_SIDE_Y: lamp = YEL;
            default:  lamp = RED;
        endcase
        return lamp;
    endfunction

endpackage

// File: rtl/traffic_light_ctrl_down_counter.sv
// -----------------------------------------------------------------------------
// Down_counter
// Loadable down-counter that times each phase of the intersection controller.
// Load takes priority over Enable, so an Enable strobe that coincides with a
// load is absorbed rather than shortening the new phase. The count saturates
// at zero; Done flags the terminal count.
//
// Ports
//   CLK     in   1           clock
//   RST_N   in   1           asynchronous active-low reset (Count -> 0)
//   Enable  in   1           decrement strobe (the external tick)
//   Load    in   1           load Preset this cycle
//   Preset  in   data_width  value loaded on Load
//   Count   out  data_width  current count (ticks left)
//   Done    out  1           Count == 0
// -----------------------------------------------------------------------------
module Down_counter #(
    parameter int data_width = 8
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  Enable,
    input  logic                  Load,
    input  logic [data_width-1:0] Preset,
    output logic [data_width-1:0] Count,
    output logic                  Done
);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            Count <= '0;
        end else if (Load) begin
            Count <= Preset;
        end else if (Enable && (Count != '0)) begin
            Count <= Count - 1'b1;
        end
    end

    assign Done = (Count == '0);

endmodule

// File: rtl/traffic_light_ctrl.sv
// -----------------------------------------------------------------------------
// traffic_light_ctrl
// Moore controller for a main/side intersection with a pedestrian walk phase.
// A single Down_counter times every phase; it is reloaded on the edge that
// enters a new state with that state's dwell, and counts down on 'tick'.
// Main green is held indefinitely once expired until a side vehicle or a
// latched pedestrian request asks for the cycle to run.
//
// Ports
//   CLK        in   1   clock
//   RST_N      in   1   asynchronous active-low reset
//   tick       in   1   one-CLK timing strobe, decrements the phase counter
//   side_req   in   1   level, side-road vehicle waiting (sampled at MAIN_G expiry)
//   ped_req    in   1   pulse, pedestrian button (latched into ped_pending)
//   main_light out  3   {R,Y,G} main road lamps, one-hot
//   side_light out  3   {R,Y,G} side road lamps, one-hot
//   walk       out  1   pedestrian walk lamp
//   state_o    out  3   current state code
//   remaining  out  W   ticks left in the current phase
// -----------------------------------------------------------------------------
module traffic_light_ctrl
    import traffic_light_ctrl_pkg::*;
#(
    parameter int W      = 8,
    parameter int T_MG   = 30,
    parameter int T_MY   = 3,
    parameter int T_AR   = 1,
    parameter int T_SG   = 20,
    parameter int T_SY   = 3,
    parameter int T_WALK = 10
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         tick,
    input  logic         side_req,
    input  logic         ped_req,
    output logic [2:0]   main_light,
    output logic [2:0]   side_light,
    output logic         walk,
    output logic [2:0]   state_o,
    output logic [W-1:0] remaining
);

    // state   | meaning
    // INIT    | post-reset, all red, leaves after one CLK
    // MAIN_G  | main green; held at count 0 until side_req or ped_pending
    // MAIN_Y  | main yellow
    // AR1     | all-red clearance before side green
    // SIDE_G  | side green
    // SIDE_Y  | side yellow
    // AR2     | all-red clearance; goes to WALK if a pedestrian is pending
    // WALK    | pedestrian walk, all roads red

    state_t       state;
    state_t       next_state;
    logic         done;
    logic         load;
    logic [W-1:0] preset;
    logic [W-1:0] count;
    logic         ped_pending;

    always_comb begin
        next_state = state;
        case (state)
            S_INIT:   next_state = S_MAIN_G;
            S_MAIN_G: if (done && (side_req || ped_pending)) next_state = S_MAIN_Y;
            S_MAIN_Y: if (done) next_state = S_AR1;
            S_AR1:    if (done) next_state = S_SIDE_G;
            S_SIDE_G: if (done) next_state = S_SIDE_Y;
            S_SIDE_Y: if (done) next_state = S_AR2;
            S_AR2:    if (done) next_state = ped_pending ? S_WALK : S_MAIN_G;
            S_WALK:   if (done) next_state = S_MAIN_G;
            default:  next_state = S_INIT;
        endcase
    end

    // No state has a transition to itself, so any change of state is an
    // entry and reloads the counter.
    assign load = (next_state != state);

    always_comb begin
        preset = '0;
        case (next_state)
            S_MAIN_G: preset = W'(T_MG);
            S_MAIN_Y: preset = W'(T_MY);
            S_AR1:    preset = W'(T_AR);
            S_SIDE_G: preset = W'(T_SG);
            S_SIDE_Y: preset = W'(T_SY);
            S_AR2:    preset = W'(T_AR);
            S_WALK:   preset = W'(T_WALK);
            default:  preset = '0;
        endcase
    end

    Down_counter #(
        .data_width (W)
    ) u_timer (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .Enable (tick),
        .Load   (load),
        .Preset (preset),
        .Count  (count),
        .Done   (done)
    );

    // Lamps are registered from next_state so they always match the state
    // register without a decode stage on the outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= S_INIT;
            main_light <= RED;
            side_light <= RED;
            walk       <= 1'b0;
        end else begin
            state      <= next_state;
            main_light <= main_lamp(next_state);
            side_light <= side_lamp(next_state);
            walk       <= (next_state == S_WALK);
        end
    end

    // A button press on the WALK-entry edge wins over the clear, so that
    // pedestrian is served on the following round.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ped_pending <= 1'b0;
        end else if (ped_req) begin
            ped_pending <= 1'b1;
        end else if ((next_state == S_WALK) && (state != S_WALK)) begin
            ped_pending <= 1'b0;
        end
    end

    assign state_o   = state;
    assign remaining = count;

    a_never_both_go: assert property (@(posedge CLK) disable iff (!RST_N)
        !((main_light != RED) && (side_light != RED)));
    a_main_onehot: assert property (@(posedge CLK) disable iff (!RST_N)
        $onehot(main_light));
    a_side_onehot: assert property (@(posedge CLK) disable iff (!RST_N)
        $onehot(side_light));
    a_walk_only_in_walk: assert property (@(posedge CLK) disable iff (!RST_N)
        walk == (state == S_WALK));

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// -----------------------------------------------------------------------------
// tb_traffic_light_ctrl
// Directed scenarios against traffic_light_ctrl (W=4, T_MG=4, T_MY=2, T_AR=1,
// T_SG=3, T_SY=2, T_WALK=2). The stimulus pushes the expected sequence of
// phases {state, starting remaining, dwell in CLKs} into a queue; a monitor
// pops one entry each time state_o changes and checks the phase entry, the
// per-cycle remaining count, the lamps and the phase length.
// Inputs change 2 ns after a rising edge; the monitor samples on falling edges.
// -----------------------------------------------------------------------------
module tb_traffic_light_ctrl;

    localparam int ST_INIT   = 0;
    localparam int ST_MAIN_G = 1;
    localparam int ST_MAIN_Y = 2;
    localparam int ST_AR1    = 3;
    localparam int ST_SIDE_G = 4;
    localparam int ST_SIDE_Y = 5;
    localparam int ST_AR2    = 6;
    localparam int ST_WALK   = 7;

    localparam int L_RED = 4;
    localparam int L_YEL = 2;
    localparam int L_GRN = 1;

    logic       CLK;
    logic       RST_N;
    logic       tick;
    logic       side_req;
    logic       ped_req;
    logic [2:0] main_light;
    logic [2:0] side_light;
    logic       walk;
    logic [2:0] state_o;
    logic [3:0] remaining;

    traffic_light_ctrl #(
        .W(4), .T_MG(4), .T_MY(2), .T_AR(1), .T_SG(3), .T_SY(2), .T_WALK(2)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .tick       (tick),
        .side_req   (side_req),
        .ped_req    (ped_req),
        .main_light (main_light),
        .side_light (side_light),
        .walk       (walk),
        .state_o    (state_o),
        .remaining  (remaining)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        int st;
        int rem;
        int dwell;   // CLKs with reset released; 0 = length not checked
    } phase_t;

    phase_t exp_q[$];
    int     n_checks = 0;
    int     n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input int st, input int rem, input int dwell);
        phase_t p;
        p.st = st;
        p.rem = rem;
        p.dwell = dwell;
        exp_q.push_back(p);
    endtask

    function automatic int exp_main(input int st);
        case (st)
            ST_MAIN_G: return L_GRN;
            ST_MAIN_Y: return L_YEL;
            default:   return L_RED;
        endcase
    endfunction

    function automatic int exp_side(input int st);
        case (st)
            ST_SIDE_G: return L_GRN;
            ST_SIDE_Y: return L_YEL;
            default:   return L_RED;
        endcase
    endfunction

    // ---------------------------------------------------------------- monitor
    initial begin
        int     prev_state;
        int     cur;
        int     exp_rem;
        int     dwell_cnt;
        bit     cur_valid;
        bit     prev_tick;
        phase_t item;
        prev_state = -1;
        exp_rem    = 0;
        dwell_cnt  = 0;
        cur_valid  = 1'b0;
        prev_tick  = 1'b0;
        item.st = 0; item.rem = 0; item.dwell = 0;
        forever begin
            @(negedge CLK);
            cur = int'(state_o);
            if (cur != prev_state) begin
                if (cur_valid && (item.dwell != 0))
                    check($sformatf("dwell_st%0d", item.st), dwell_cnt, item.dwell);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_phase: got state %0d, expected no change", cur);
                    cur_valid = 1'b0;
                end else begin
                    item = exp_q.pop_front();
                    cur_valid = 1'b1;
                    check("phase_state", cur, item.st);
                    exp_rem = item.rem;
                end
                dwell_cnt = RST_N ? 1 : 0;
            end else begin
                if (RST_N) dwell_cnt++;
                if (prev_tick && (exp_rem > 0)) exp_rem--;
            end
            if (cur_valid) begin
                check($sformatf("remaining_st%0d", item.st), int'(remaining), exp_rem);
                check($sformatf("main_light_st%0d", item.st), int'(main_light), exp_main(item.st));
                check($sformatf("side_light_st%0d", item.st), int'(side_light), exp_side(item.st));
                check($sformatf("walk_st%0d", item.st), int'(walk), (item.st == ST_WALK) ? 1 : 0);
            end
            check("both_roads_non_red", int'((main_light != 3'b100) && (side_light != 3'b100)), 0);
            prev_tick  = tick;
            prev_state = cur;
        end
    end

    // --------------------------------------------------------------- stimulus
    task automatic wait_state(input int s, input int max_cycles);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < max_cycles && !seen; k++) begin
            @(posedge CLK);
            #1;
            if (int'(state_o) == s) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL wait_state: got state %0d, expected %0d within %0d cycles",
                     state_o, s, max_cycles);
        end
    endtask

    // Entered at MAIN_G entry + 1 ns. A one-CLK side_req early in the phase
    // must be lost; the final request makes the phase last exactly n CLKs.
    task automatic main_hold(input int n);
        #1 side_req = 1'b1;
        @(posedge CLK);
        #2 side_req = 1'b0;
        repeat (n - 2) @(posedge CLK);
        #2 side_req = 1'b1;
    endtask

    task automatic run_round(input int hold, input int next_hold,
                             input bit ped_side, input bit ped_walk_edge,
                             input bit walk_exp);
        push(ST_MAIN_Y, 2, 3);
        push(ST_AR1,    1, 2);
        push(ST_SIDE_G, 3, 4);
        push(ST_SIDE_Y, 2, 3);
        push(ST_AR2,    1, 2);
        if (walk_exp) push(ST_WALK, 2, 3);
        push(ST_MAIN_G, 4, next_hold);
        main_hold(hold);
        wait_state(ST_MAIN_Y, 20);
        #1 side_req = 1'b0;
        if (ped_side) begin
            wait_state(ST_SIDE_G, 20);
            #1 ped_req = 1'b1;
            @(posedge CLK);
            #2 ped_req = 1'b0;
        end
        if (ped_walk_edge) begin
            wait_state(ST_AR2, 20);
            @(posedge CLK);
            #2 ped_req = 1'b1;   // high only for the WALK-entry edge
            @(posedge CLK);
            #2 ped_req = 1'b0;
        end
        wait_state(ST_MAIN_G, 30);
    endtask

    initial begin
        RST_N    = 1'b0;
        tick     = 1'b1;
        side_req = 1'b0;
        ped_req  = 1'b0;

        // 1: INIT for one CLK, MAIN_G counts 4..0 and holds with no request
        push(ST_INIT,   0, 1);
        push(ST_MAIN_G, 4, 10);
        repeat (3) @(posedge CLK);
        #2 RST_N = 1'b1;
        wait_state(ST_MAIN_G, 5);

        // 2: plain side cycle back to MAIN_G
        run_round(10, 5, 1'b0, 1'b0, 1'b0);
        // 3: pedestrian press during SIDE_G gives a WALK phase
        run_round(5, 5, 1'b1, 1'b0, 1'b1);
        // 4: press again in SIDE_G and on the WALK-entry edge
        run_round(5, 5, 1'b1, 1'b1, 1'b1);
        // request survived the WALK entry: another WALK without a press
        run_round(5, 5, 1'b0, 1'b0, 1'b1);
        // pending cleared by that WALK entry: no WALK this time
        run_round(5, 5, 1'b0, 1'b0, 1'b0);

        // 5: asynchronous reset in SIDE_G with remaining=2
        push(ST_MAIN_Y, 2, 3);
        push(ST_AR1,    1, 2);
        push(ST_SIDE_G, 3, 1);
        push(ST_INIT,   0, 1);
        push(ST_MAIN_G, 4, 0);
        main_hold(5);
        wait_state(ST_MAIN_Y, 20);
        #1 side_req = 1'b0;
        wait_state(ST_SIDE_G, 20);
        @(posedge CLK);
        #2;
        check("pre_reset_remaining", int'(remaining), 2);
        RST_N = 1'b0;
        #1;
        check("async_reset_state", int'(state_o), ST_INIT);
        check("async_reset_remaining", int'(remaining), 0);
        check("async_reset_main", int'(main_light), L_RED);
        check("async_reset_side", int'(side_light), L_RED);
        check("async_reset_walk", int'(walk), 0);
        repeat (2) @(posedge CLK);
        #2 RST_N = 1'b1;
        wait_state(ST_MAIN_G, 5);
        repeat (6) @(posedge CLK);
        #2;

        // 6: tick every 3rd CLK, one tick on the MAIN_Y load edge
        push(ST_MAIN_Y, 2, 7);
        push(ST_AR1,    1, 3);
        push(ST_SIDE_G, 3, 9);
        push(ST_SIDE_Y, 2, 6);
        push(ST_AR2,    1, 3);
        push(ST_MAIN_G, 4, 0);
        for (int k = 0; k < 35; k++) begin
            tick     = ((k % 3) == 0);
            side_req = (k == 0);
            @(posedge CLK);
            #2;
        end
        tick = 1'b1;
        repeat (3) @(posedge CLK);
        #2;
        check("expected_queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected end of test");
        $fatal(1, "watchdog");
    end

endmodule
